// File: rtl/spi_txn_arbiter.sv
// rtl/spi_txn_arbiter.sv - round-robin arbiter/sequencer sharing one SPI master; optional watchdog via SPI_ARB_TIMEOUT_EN
module spi_txn_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 12,
  parameter int TIMEOUT = 1023,
  localparam int IW     = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    ack,
  output logic               busy,
  output logic [IW-1:0]      grant_id,
  output logic               newd,
  output logic [DW-1:0]      din,
  input  logic               cs,
  output logic               err
);

  typedef enum logic [1:0] {IDLE, WAIT_START, WAIT_END} state_t;

  state_t            state, state_n;
  logic [IW-1:0]     rr_ptr, rr_n;
  logic [IW-1:0]     grant_n;
  logic [DW-1:0]     din_n;
  logic [NREQ-1:0]   ack_n;
  logic              busy_n, newd_n;
  logic [DW-1:0]     words [NREQ];
  logic              pick_found;
  logic [IW-1:0]     pick_id;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]     timer, timer_n;
  logic              err_n;
`else
  assign err = 1'b0;
`endif

  // Unpack the flat request word bus into one word per requester
  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      words[k] = req_data[k*DW +: DW];
    end
  end

  // Pick the first pending requester at or above rr_ptr, wrapping around
  always_comb begin
    int j;
    logic [IW-1:0] cand;
    pick_found = 1'b0;
    pick_id    = '0;
    j          = 0;
    cand       = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      cand = IW'(j);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_n = state;
    rr_n    = rr_ptr;
    grant_n = grant_id;
    din_n   = din;
    ack_n   = '0;
    newd_n  = 1'b0;
    busy_n  = busy;
`ifdef SPI_ARB_TIMEOUT_EN
    timer_n = timer;
    err_n   = 1'b0;
`endif
    case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (pick_found) begin
          grant_n = pick_id;
          din_n   = words[pick_id];
          newd_n  = 1'b1;
          busy_n  = 1'b1;
          state_n = WAIT_START;
          rr_n    = (pick_id == IW'(NREQ - 1)) ? '0 : pick_id + 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
          timer_n = '0;
`endif
        end
      end
      WAIT_START: begin
        if (!cs) begin
          state_n = WAIT_END;
`ifdef SPI_ARB_TIMEOUT_EN
          timer_n = '0;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          err_n           = 1'b1;
          ack_n[grant_id] = 1'b1;
          state_n         = IDLE;
        end else begin
          timer_n = timer + 1'b1;
`endif
        end
      end
      WAIT_END: begin
        if (cs) begin
          ack_n[grant_id] = 1'b1;
          state_n         = IDLE;
`ifdef SPI_ARB_TIMEOUT_EN
        end else if (timer == TW'(TIMEOUT - 1)) begin
          err_n           = 1'b1;
          ack_n[grant_id] = 1'b1;
          state_n         = IDLE;
        end else begin
          timer_n = timer + 1'b1;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      din      <= '0;
      ack      <= '0;
      newd     <= 1'b0;
      busy     <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      timer    <= '0;
      err      <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_n;
      grant_id <= grant_n;
      din      <= din_n;
      ack      <= ack_n;
      newd     <= newd_n;
      busy     <= busy_n;
`ifdef SPI_ARB_TIMEOUT_EN
      timer    <= timer_n;
      err      <= err_n;
`endif
    end
  end

endmodule

// File: doc/spi_txn_arbiter.md
Name: spi_txn_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 12-bit SPI master (newd/din in, cs out) among NREQ requesters.
- Latches the granted requester's word and pulses newd to start the transfer.
- Tracks the master's cs low→high to detect completion, then acks the requester.
- Sits between client logic and spi_master inside top.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 12, data width per transfer; must match the master's din width
TIMEOUT, 1023, watchdog limit in clk cycles per transfer phase (used only with the optional feature)

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  asynchronous, active-high reset
req  input  NREQ  per-requester request level; held until matching ack
req_data  input  NREQ*DW  packed words; requester i occupies bits [i*DW +: DW]
ack  output  NREQ  one-hot, one-cycle completion pulse
busy  output  1  high from grant until the ack cycle, inclusive
grant_id  output  $clog2(NREQ)  index of current/last granted requester
newd  output  1  one-cycle start pulse to the SPI master
din  output  DW  word to the SPI master; stable from grant until return to IDLE
cs  input  1  chip select observed from the SPI master, active low
err  output  1  one-cycle timeout pulse; tied 0 when the feature is disabled

Behaviour:
- Reset (async, rst=1) sets outputs: ack=0, busy=0, grant_id=0, newd=0, din=0, err=0.
- Reset sets internal state: state=IDLE, rr_ptr=0, timers cleared.
- All outputs are registered.
- States: IDLE, WAIT_START, WAIT_END.
- IDLE: if any req bit is set, select the first set bit searching from rr_ptr upward, wrapping modulo NREQ. At that edge:
  - grant_id<=i, din<=req_data[i], newd<=1, busy<=1, state<=WAIT_START.
  - rr_ptr<=(i+1) mod NREQ.
- IDLE with no req: hold; newd=0, busy=0.
- WAIT_START:
  - newd is forced to 0 on the edge after grant, so it is exactly one cycle wide.
  - On an edge sampling cs==0, state<=WAIT_END.
- WAIT_END: on an edge sampling cs==1, ack[grant_id]<=1, state<=IDLE; busy drops one cycle later, so busy stays high through the ack cycle.
- ack self-clears after one cycle.
- IDLE may grant again on the same edge that clears ack. A requester must drop req in the ack cycle or it is eligible for re-grant.
  - Rotation still moves priority past it, so other pending requesters are served first.
- req sampling:
  - Sampled only in IDLE.
  - req changes during a transfer are ignored.
  - Dropping req after grant does not cancel the transfer; ack is still issued.
- Simultaneous requests: exactly one grant per transfer, never two ack bits set.
- Fairness: with all NREQ requesting continuously, grant order is 0,1,2,3,0,… from reset.
- cs already low when entering WAIT_START (master stuck): accepted as the start; transfer proceeds normally.
- Reset mid-transfer: immediate return to IDLE, outputs to reset values, no ack issued, rr_ptr=0.
- Latency: req high at edge k → newd high in cycle k..k+1. Ack follows 1 cycle after cs returns high.

Optional Feature:
- SPI_ARB_TIMEOUT_EN defined:
  - A cycle counter clears on entry to WAIT_START and on WAIT_START→WAIT_END.
  - If it reaches TIMEOUT in either state, err<=1 and ack[grant_id]<=1 for one cycle, state<=IDLE, rr_ptr advances normally.
  - Counter width is $clog2(TIMEOUT+1).
- Not defined:
  - No counter; WAIT states wait indefinitely.
  - err is a constant 0.

Test Plan:
- Single request: req=4'b0010, req_data[1]=12'hA5C → grant_id=1, din=12'hA5C, newd one cycle; on cs low→high, ack=4'b0010 for one cycle; master/slave dout=12'hA5C.
- All request after reset, req=4'b1111 held with distinct words 12'h001..12'h004 → four transfers, grant order 0,1,2,3, then 0 again; each ack one-hot, never overlapping.
- Round-robin skip: last grant id 2, then req=4'b0011 → next grant 0, not 1 (rr_ptr=3 wraps to 0).
- Mid-transfer changes: req_data[0] and req[0] changed during WAIT_END → din unchanged, ack still asserted for requester 0.
- Reset mid-transfer: assert rst during WAIT_END → all outputs 0 asynchronously, no ack. After release, new req=4'b1000 grants id 3.
- With SPI_ARB_TIMEOUT_EN, TIMEOUT=15: hold cs=1 after newd → err and ack pulse exactly 15 cycles after grant, busy=0 next cycle. Without the macro, busy stays 1 indefinitely and err=0.
